// File: rtl/gf15_pkg.sv
// Shared definitions for the GF(2^15) reduction block, field x^15 + x + 1.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Vectors are ascending-indexed: element [i] is the coefficient of x^i.
package gf15_pkg;

    localparam int GF15_W  = 15;   // field element width
    localparam int GF15_PW = 29;   // unreduced 15x15 product width

    // Bit i is the coefficient of x^i: x^15 + x + 1.
    localparam logic [GF15_W:0] GF15_POLY = 16'h8003;

    typedef logic [0:GF15_W-1]  gf15_elem_t;
    typedef logic [0:GF15_PW-1] gf15_prod_t;

endpackage

// File: rtl/gf15_fold.sv
// Single-fold reduction of a 29-bit GF(2) product modulo x^15 + x + 1.
// Latency: combinational.
// Backpressure: none (pure function).
// Ports: prod [0:28] unreduced product (index = power of x); elem [0:14] reduced element.
module gf15_fold
    import gf15_pkg::*;
(
    input  logic [0:28] prod,
    output logic [0:14] elem
);

    // x^j for j in 15..28 equals x^(j-14) + x^(j-15), and j-14 <= 14, so one
    // fold of the high half lands entirely inside the field width.
    always_comb begin
        elem     = '0;
        elem[0]  = prod[0] ^ prod[15];
        for (int i = 1; i <= 13; i++) begin
            elem[i] = prod[i] ^ prod[i+14] ^ prod[i+15];
        end
        elem[14] = prod[14] ^ prod[28];
    end

endmodule

// File: rtl/gf15_reduce.sv
// Two-stage valid/ready pipeline reducing GF(2) products to GF(2^15) elements.
// Latency: 2 cycles from input transfer to out_valid; 1 word/cycle with out_ready high.
// Backpressure: each stage advances when its successor is empty or draining; in_ready low only when both stages are full and out_ready is low.
// Ports: clk/rst (sync active-high); in_valid/in_ready/in_prod[0:28]/in_acc_clr;
//        out_valid/out_ready/out_elem[0:14].
// Optional feature macro GF15_RED_ACC_EN: S2 becomes an XOR accumulator,
// loaded instead of XORed when the word carried in_acc_clr.
module gf15_reduce
    import gf15_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:28] in_prod,
    input  logic        in_acc_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:14] out_elem
);

    // S1: captured product
    logic       s1_vld_q, s1_vld_d;
    gf15_prod_t s1_prod_q, s1_prod_d;
    // S2: reduced result (or accumulator)
    logic       s2_vld_q, s2_vld_d;
    gf15_elem_t s2_elem_q, s2_elem_d;

    logic       s2_adv;
    logic       in_fire;
    logic       s1_move;
    gf15_elem_t fold_elem;

`ifdef GF15_RED_ACC_EN
    logic s1_clr_q, s1_clr_d;
`else
    logic unused_acc_clr;
    assign unused_acc_clr = in_acc_clr;
`endif

    gf15_fold u_fold (
        .prod (s1_prod_q),
        .elem (fold_elem)
    );

    always_comb begin
        // S2 can take a new word when empty or when its word leaves this cycle.
        s2_adv    = !s2_vld_q || out_ready;
        in_ready  = !s1_vld_q || s2_adv;
        in_fire   = in_valid && in_ready;
        s1_move   = s1_vld_q && s2_adv;

        s1_vld_d  = in_fire ? 1'b1 : (s1_move ? 1'b0 : s1_vld_q);
        s1_prod_d = in_fire ? in_prod : s1_prod_q;
        s2_vld_d  = s1_move || (s2_vld_q && !out_ready);

        s2_elem_d = s2_elem_q;
`ifdef GF15_RED_ACC_EN
        s1_clr_d  = in_fire ? in_acc_clr : s1_clr_q;
        // The accumulator keeps its value after a drain; only a new word changes it.
        if (s1_move) begin
            s2_elem_d = s1_clr_q ? fold_elem : (s2_elem_q ^ fold_elem);
        end
`else
        if (s1_move) begin
            s2_elem_d = fold_elem;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_elem_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s2_vld_d;
            s2_elem_q <= s2_elem_d;
        end
    end

    // Captured product needs no reset: it is only consumed when s1_vld_q is set.
    always_ff @(posedge clk) begin
        s1_prod_q <= s1_prod_d;
`ifdef GF15_RED_ACC_EN
        s1_clr_q  <= s1_clr_d;
`endif
    end

    assign out_valid = s2_vld_q;
    assign out_elem  = s2_elem_q;

endmodule

// File: tb/tb_gf15_reduce.sv
// Testbench for gf15_reduce: directed vectors, random stalled stream, reset flush.
// Reference model reduces by polynomial long division on plain integers.
// Define GF15_RED_ACC_EN for both DUT and bench to exercise the accumulator.
module tb_gf15_reduce;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [0:28] in_prod;
    logic        in_acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [0:14] out_elem;

    int tests  = 0;
    int failed = 0;

    logic [14:0] acc_m;
    logic [14:0] exp_q[$];

    gf15_reduce dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .in_acc_clr (in_acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_elem   (out_elem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Integer value bit i -> coefficient of x^i.
    function automatic logic [0:28] to_prod(input logic [28:0] v);
        logic [0:28] p;
        for (int i = 0; i < 29; i++) p[i] = v[i];
        return p;
    endfunction

    function automatic logic [14:0] from_elem(input logic [0:14] e);
        logic [14:0] v;
        for (int i = 0; i < 15; i++) v[i] = e[i];
        return v;
    endfunction

    // Remainder of v modulo x^15 + x + 1 by long division.
    function automatic logic [14:0] ref_reduce(input logic [28:0] v);
        logic [29:0] r;
        logic [29:0] poly;
        r    = {1'b0, v};
        poly = 30'h8003;
        for (int j = 28; j >= 15; j--) begin
            if (r[j]) r = r ^ (poly << (j - 15));
        end
        return r[14:0];
    endfunction

    // Expected output for an accepted word; tracks accumulator state.
    function automatic logic [14:0] model_out(input logic [28:0] v, input logic clr);
        logic [14:0] r;
        r = ref_reduce(v);
`ifdef GF15_RED_ACC_EN
        acc_m = clr ? r : (acc_m ^ r);
        return acc_m;
`else
        return r;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated word with out_ready high: accepted now, visible exactly 2 cycles later, alone.
    task automatic directed(input string tag, input logic [28:0] v, input logic clr,
                            input logic [14:0] exp);
        logic [14:0] unused_m;
        @(negedge clk);
        in_valid   = 1'b1;
        in_prod    = to_prod(v);
        in_acc_clr = clr;
        out_ready  = 1'b1;
        #1 check({tag, "_in_ready"}, in_ready, 1);
        unused_m = model_out(v, clr);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, "_lat1_valid"}, out_valid, 0);
        @(negedge clk);
        #1 check({tag, "_lat2_valid"}, out_valid, 1);
        check({tag, "_elem"}, from_elem(out_elem), exp);
        @(negedge clk);
        #1 check({tag, "_drained"}, out_valid, 0);
    endtask

    task automatic random_stream();
        int          sent;
        int          stall;
        logic        held;
        logic [14:0] prev_elem;
        logic [28:0] v;
        logic [14:0] e;
        sent  = 0;
        stall = 0;
        held  = 1'b0;
        prev_elem = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 3000 && (sent < 50 || exp_q.size() > 0); cyc++) begin
            @(negedge clk);
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 7) == 0) begin
                out_ready = 1'b0;
                stall = 4;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (sent < 50) begin
                in_valid   = ($urandom_range(0, 9) != 0);
                v          = 29'($urandom);
                in_prod    = to_prod(v);
                in_acc_clr = ($urandom_range(0, 3) == 0);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                check("stall_valid", out_valid, 1);
                check("stall_elem", from_elem(out_elem), prev_elem);
            end
            check("in_ready_occ", in_ready, !(exp_q.size() == 2 && !out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_elem", from_elem(out_elem), e);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_out(v, in_acc_clr));
                sent++;
            end
            held      = out_valid && !out_ready;
            prev_elem = from_elem(out_elem);
        end
        check("stream_sent", sent, 50);
        check("stream_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [28:0] v3;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_prod    = '0;
        in_acc_clr = 1'b0;
        out_ready  = 1'b1;
        acc_m      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_elem", from_elem(out_elem), 0);
        rst = 1'b0;
        @(negedge clk);
        #1 check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        directed("x15",   29'h0000_8000, 1'b1, 15'h0003);
        directed("x28",   29'h1000_0000, 1'b1, 15'h6000);
        directed("ones",  29'h1FFF_FFFF, 1'b1, 15'h3FFE);
        directed("low15", 29'h0000_7FFF, 1'b1, 15'h7FFF);

        random_stream();

        // Reset with two words in flight and the output stalled.
        @(negedge clk);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_acc_clr = 1'b1;
        in_prod    = to_prod(29'h0ABC_1234);
        @(negedge clk);
        in_prod    = to_prod(29'h1234_5678);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("pre_rst_full", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        #1 check("mid_rst_valid", out_valid, 0);
        check("mid_rst_elem", from_elem(out_elem), 0);
        rst   = 1'b0;
        acc_m = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 check("no_stale_valid", out_valid, 0);
            check("post_rst_ready", in_ready, 1);
        end
        v3 = 29'h1555_AAAA;
        directed("after_rst", v3, 1'b0, ref_reduce(v3));

`ifdef GF15_RED_ACC_EN
        directed("acc_load", 29'h0000_8000, 1'b1, 15'h0003);
        directed("acc_xor",  29'h1000_0000, 1'b0, 15'h6003);
        directed("acc_clr",  29'h0000_8000, 1'b1, 15'h0003);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
